// File: rtl/lc3b_types.sv
// Shared LC-3b memory-side types and the L2 port scheduler state encoding.
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_cacheline;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } sched_state_e;

  typedef enum logic {
    SIDE_I = 1'b0,
    SIDE_D = 1'b1
  } side_e;

endpackage

// File: rtl/sched_rr_pick.sv
// Two-way round-robin pick between the I-side and D-side miss requests.
module sched_rr_pick
  import lc3b_types::*;
(
  input  logic  i_req_i,
  input  logic  d_req_i,
  input  side_e last_served_i,
  output logic  i_grant_o,
  output logic  d_grant_o
);

  // On a tie the side that was not served last wins.
  assign d_grant_o = d_req_i & (~i_req_i | (last_served_i == SIDE_I));
  assign i_grant_o = i_req_i & ~d_grant_o;

endmodule

// File: rtl/l2_port_scheduler.sv
// Arbitrates the I-side and D-side L1 miss ports onto a single registered L2 port.
module l2_port_scheduler
  import lc3b_types::*;
#(
  parameter int CNT_W = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_read,
  input  logic          i_write,
  input  lc3b_word      i_address,
  input  lc3b_cacheline i_wdata,
  input  logic          d_read,
  input  logic          d_write,
  input  lc3b_word      d_address,
  input  lc3b_cacheline d_wdata,
  output logic          i_resp,
  output logic          d_resp,
  output lc3b_cacheline i_rdata,
  output lc3b_cacheline d_rdata,
  output logic          l2_read,
  output logic          l2_write,
  output lc3b_word      l2_address,
  output lc3b_cacheline l2_wdata,
  input  logic          l2_resp,
  input  lc3b_cacheline l2_rdata,
  output logic [CNT_W-1:0] i_grants,
  output logic [CNT_W-1:0] d_grants
);

  sched_state_e     state_q;
  side_e            last_served_q;
  logic             l2_read_q, l2_write_q;
  lc3b_word         l2_address_q;
  lc3b_cacheline    l2_wdata_q;
  logic [CNT_W-1:0] i_grants_q, d_grants_q;
  logic [CNT_W-1:0] i_grants_d, d_grants_d;
  logic             i_grant, d_grant;

  sched_rr_pick u_pick (
    .i_req_i       (i_read | i_write),
    .d_req_i       (d_read | d_write),
    .last_served_i (last_served_q),
    .i_grant_o     (i_grant),
    .d_grant_o     (d_grant)
  );

  assign i_grants_d = (&i_grants_q) ? i_grants_q : i_grants_q + CNT_W'(1);
  assign d_grants_d = (&d_grants_q) ? d_grants_q : d_grants_q + CNT_W'(1);

  // A write wins over a simultaneous read from the same side; the read is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      last_served_q <= SIDE_I;
      l2_read_q     <= 1'b0;
      l2_write_q    <= 1'b0;
      l2_address_q  <= '0;
      l2_wdata_q    <= '0;
      i_grants_q    <= '0;
      d_grants_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_grant) begin
            state_q      <= BUSY_I;
            l2_write_q   <= i_write;
            l2_read_q    <= i_read & ~i_write;
            l2_address_q <= i_address;
            l2_wdata_q   <= i_wdata;
          end else if (d_grant) begin
            state_q      <= BUSY_D;
            l2_write_q   <= d_write;
            l2_read_q    <= d_read & ~d_write;
            l2_address_q <= d_address;
            l2_wdata_q   <= d_wdata;
          end
        end
        BUSY_I: begin
          if (l2_resp) begin
            state_q       <= IDLE;
            l2_read_q     <= 1'b0;
            l2_write_q    <= 1'b0;
            last_served_q <= SIDE_I;
            i_grants_q    <= i_grants_d;
          end
        end
        BUSY_D: begin
          if (l2_resp) begin
            state_q       <= IDLE;
            l2_read_q     <= 1'b0;
            l2_write_q    <= 1'b0;
            last_served_q <= SIDE_D;
            d_grants_q    <= d_grants_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign i_resp     = (state_q == BUSY_I) & l2_resp;
  assign d_resp     = (state_q == BUSY_D) & l2_resp;
  assign i_rdata    = l2_rdata;
  assign d_rdata    = l2_rdata;
  assign l2_read    = l2_read_q;
  assign l2_write   = l2_write_q;
  assign l2_address = l2_address_q;
  assign l2_wdata   = l2_wdata_q;
  assign i_grants   = i_grants_q;
  assign d_grants   = d_grants_q;

endmodule

// File: tb/tb_l2_port_scheduler.sv
// Directed bench for l2_port_scheduler; a CNT_W=2 copy runs in lockstep for saturation.
module tb_l2_port_scheduler;

  logic         clk, rst_n;
  logic         i_read, i_write, d_read, d_write;
  logic [15:0]  i_address, d_address;
  logic [127:0] i_wdata, d_wdata;
  logic         l2_resp;
  logic [127:0] l2_rdata;

  logic         i_resp, d_resp, l2_read, l2_write;
  logic [127:0] i_rdata, d_rdata, l2_wdata;
  logic [15:0]  l2_address;
  logic [15:0]  i_grants, d_grants;

  logic         s_i_resp, s_d_resp, s_l2_read, s_l2_write;
  logic [127:0] s_i_rdata, s_d_rdata, s_l2_wdata;
  logic [15:0]  s_l2_address;
  logic [1:0]   s_i_grants, s_d_grants;

  int vectors = 0;
  int miscompares = 0;

  l2_port_scheduler dut (
    .clk(clk), .rst_n(rst_n),
    .i_read(i_read), .i_write(i_write), .i_address(i_address), .i_wdata(i_wdata),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .i_resp(i_resp), .d_resp(d_resp), .i_rdata(i_rdata), .d_rdata(d_rdata),
    .l2_read(l2_read), .l2_write(l2_write), .l2_address(l2_address), .l2_wdata(l2_wdata),
    .l2_resp(l2_resp), .l2_rdata(l2_rdata),
    .i_grants(i_grants), .d_grants(d_grants)
  );

  l2_port_scheduler #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n),
    .i_read(i_read), .i_write(i_write), .i_address(i_address), .i_wdata(i_wdata),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .i_resp(s_i_resp), .d_resp(s_d_resp), .i_rdata(s_i_rdata), .d_rdata(s_d_rdata),
    .l2_read(s_l2_read), .l2_write(s_l2_write), .l2_address(s_l2_address), .l2_wdata(s_l2_wdata),
    .l2_resp(l2_resp), .l2_rdata(l2_rdata),
    .i_grants(s_i_grants), .d_grants(s_d_grants)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic ir, input logic iw, input logic dr, input logic dw);
    i_read  = ir;
    i_write = iw;
    d_read  = dr;
    d_write = dw;
  endtask

  initial begin
    rst_n = 1'b0; l2_resp = 1'b0; l2_rdata = '0;
    applyStimulus(0, 0, 0, 0);
    i_address = '0; d_address = '0; i_wdata = '0; d_wdata = '0;
    cyc(); cyc();

    checkOutput("rst_l2_read", l2_read, 1'b0);
    checkOutput("rst_l2_write", l2_write, 1'b0);
    checkOutput("rst_l2_address", l2_address, 16'h0);
    checkOutput("rst_l2_wdata", l2_wdata, 128'h0);
    checkOutput("rst_i_grants", i_grants, 16'd0);
    checkOutput("rst_d_grants", d_grants, 16'd0);

    // Single I read, grant in the first cycle after reset release.
    rst_n = 1'b1;
    i_address = 16'h1230;
    applyStimulus(1, 0, 0, 0);
    #1 checkOutput("s1_no_cmd_yet", l2_read, 1'b0);
    cyc();
    checkOutput("s1_l2_read", l2_read, 1'b1);
    checkOutput("s1_l2_write", l2_write, 1'b0);
    checkOutput("s1_l2_address", l2_address, 16'h1230);
    checkOutput("s1_i_resp_early", i_resp, 1'b0);
    cyc(); cyc();
    checkOutput("s1_l2_read_held", l2_read, 1'b1);
    l2_resp = 1'b1;
    l2_rdata = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    #1;
    checkOutput("s1_i_resp", i_resp, 1'b1);
    checkOutput("s1_d_resp", d_resp, 1'b0);
    checkOutput("s1_i_rdata", i_rdata, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
    cyc();
    l2_resp = 1'b0;
    applyStimulus(0, 0, 0, 0);
    #1;
    checkOutput("s1_i_resp_gone", i_resp, 1'b0);
    checkOutput("s1_l2_read_drop", l2_read, 1'b0);
    checkOutput("s1_i_grants", i_grants, 16'd1);

    // Stray l2_resp while idle.
    l2_resp = 1'b1;
    #1;
    checkOutput("idle_resp_i", i_resp, 1'b0);
    checkOutput("idle_resp_d", d_resp, 1'b0);
    cyc();
    l2_resp = 1'b0;
    checkOutput("idle_i_grants", i_grants, 16'd1);
    checkOutput("idle_d_grants", d_grants, 16'd0);

    // Tie from reset: D first (write), then I, one idle cycle between.
    rst_n = 1'b0;
    cyc();
    checkOutput("s2_rst_i_grants", i_grants, 16'd0);
    i_address = 16'h2000;
    d_address = 16'h4000;
    d_wdata = {16{8'hA5}};
    applyStimulus(1, 0, 0, 1);
    rst_n = 1'b1;
    cyc();
    checkOutput("s2_d_l2_write", l2_write, 1'b1);
    checkOutput("s2_d_l2_read", l2_read, 1'b0);
    checkOutput("s2_d_l2_address", l2_address, 16'h4000);
    checkOutput("s2_d_l2_wdata", l2_wdata, {16{8'hA5}});
    d_address = 16'h5000;
    cyc();
    checkOutput("s2_addr_stable", l2_address, 16'h4000);
    l2_resp = 1'b1;
    #1;
    checkOutput("s2_d_resp", d_resp, 1'b1);
    checkOutput("s2_i_resp_ng", i_resp, 1'b0);
    checkOutput("s2_addr_at_resp", l2_address, 16'h4000);
    cyc();
    l2_resp = 1'b0;
    applyStimulus(1, 0, 0, 0);
    checkOutput("s2_gap_read", l2_read, 1'b0);
    checkOutput("s2_gap_write", l2_write, 1'b0);
    cyc();
    checkOutput("s2_i_l2_read", l2_read, 1'b1);
    checkOutput("s2_i_l2_address", l2_address, 16'h2000);
    l2_resp = 1'b1;
    #1;
    checkOutput("s2_i_resp", i_resp, 1'b1);
    cyc();
    l2_resp = 1'b0;
    applyStimulus(0, 0, 0, 0);
    checkOutput("s2_i_grants", i_grants, 16'd1);
    checkOutput("s2_d_grants", d_grants, 16'd1);

    // Read and write together on D: write is taken.
    d_address = 16'h0042;
    applyStimulus(0, 0, 1, 1);
    cyc();
    checkOutput("rw_l2_write", l2_write, 1'b1);
    checkOutput("rw_l2_read", l2_read, 1'b0);
    l2_resp = 1'b1;
    cyc();
    l2_resp = 1'b0;
    applyStimulus(0, 0, 0, 0);
    checkOutput("rw_d_grants", d_grants, 16'd2);

    // Continuous contention alternates D,I,D,I,D,I.
    rst_n = 1'b0;
    cyc();
    i_address = 16'h1111;
    d_address = 16'h2222;
    applyStimulus(1, 0, 1, 0);
    rst_n = 1'b1;
    cyc();
    for (int k = 0; k < 6; k++) begin
      checkOutput("alt_l2_read", l2_read, 1'b1);
      checkOutput("alt_address", l2_address, (k % 2 == 0) ? 16'h2222 : 16'h1111);
      l2_resp = 1'b1;
      #1;
      checkOutput("alt_d_resp", d_resp, (k % 2 == 0) ? 1'b1 : 1'b0);
      checkOutput("alt_i_resp", i_resp, (k % 2 == 0) ? 1'b0 : 1'b1);
      cyc();
      l2_resp = 1'b0;
      checkOutput("alt_gap", l2_read, 1'b0);
      if (k == 5) applyStimulus(0, 0, 0, 0);
      cyc();
    end
    checkOutput("alt_i_grants", i_grants, 16'd3);
    checkOutput("alt_d_grants", d_grants, 16'd3);
    checkOutput("alt_idle", l2_read, 1'b0);

    // Reset in the middle of a busy I transaction.
    i_address = 16'h7777;
    applyStimulus(1, 0, 0, 0);
    cyc();
    checkOutput("mid_l2_read", l2_read, 1'b1);
    rst_n = 1'b0;
    l2_resp = 1'b1;
    #1;
    checkOutput("mid_async_drop", l2_read, 1'b0);
    checkOutput("mid_no_resp", i_resp, 1'b0);
    checkOutput("mid_i_grants", i_grants, 16'd0);
    checkOutput("mid_d_grants", d_grants, 16'd0);
    applyStimulus(0, 0, 0, 0);
    cyc();
    l2_resp = 1'b0;
    rst_n = 1'b1;
    cyc();
    checkOutput("mid_idle_after", l2_read, 1'b0);
    checkOutput("mid_i_grants_after", i_grants, 16'd0);

    // Five D transactions: 2-bit counter stops at 3.
    d_address = 16'h3000;
    for (int k = 0; k < 5; k++) begin
      applyStimulus(0, 0, 1, 0);
      cyc();
      l2_resp = 1'b1;
      cyc();
      l2_resp = 1'b0;
      applyStimulus(0, 0, 0, 0);
    end
    checkOutput("sat_d_grants_w2", s_d_grants, 2'd3);
    checkOutput("sat_d_grants_w16", d_grants, 16'd5);
    checkOutput("sat_i_grants_w2", s_i_grants, 2'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
